nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit add/subtract unit built around one adder_4bits slice.
//  Sequences operands through the 4-bit adder one nibble per clock, LSB first.
//  Registers the inter-nibble carry and assembles result, carry and flags.
//  Sits upstream of (and drives) the adder_4bits instance; valid/ready on both sides.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of 4 and >= 8
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous active-high reset
//  in_valid   in   1      operands a, b, sub are valid this cycle
//  in_ready   out  1      unit can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: a+b; 1: a-b (computed as a+~b+1)
//  out_valid  out  1      result/flags valid; held until accepted
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  sum or difference
//  cout       out  1      carry out of MSB (sub: 1 = no borrow)
//  overflow   out  1      signed overflow
//  zero       out  1      result == 0
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, result=0,
//   cout=0, overflow=0, zero=0, nibble counter=0, carry reg=0.
//  NIB = WIDTH/4. Counter width clog2(NIB).
//  FSM states:
//   IDLE: in_ready=1. in_valid=1 at edge: latch a, b^{WIDTH{sub}}; carry<=sub;
//         cnt<=0; -> RUN. Else stay.
//   RUN:  in_ready=0. adder_4bits gets a_q[4*cnt+:4], b_q[4*cnt+:4], carry.
//         Each edge: result[4*cnt+:4]<=sum; carry<=cout_slice; cnt<=cnt+1.
//         On edge with cnt==NIB-1: cout<=cout_slice;
//         overflow<=a_q[W-1]~^b_q[W-1] & (sum[3]^a_q[W-1]) (b_q already inverted);
//         zero<=(final result==0); -> DONE.
//   DONE: out_valid=1, in_ready=0; result/flags stable.
//         out_ready=1 at edge -> IDLE (out_valid=0 next cycle).
//  Latency: accept at edge T; out_valid high from edge T+NIB onward.
//  Throughput: one op per NIB+2 cycles min. No IDLE bypass from DONE:
//   new operands not accepted in the same cycle the result is consumed.
//  in_valid in RUN/DONE is ignored (in_ready=0); upstream must hold.
//  a/b changes after acceptance have no effect (operands registered).
//  result holds last value in IDLE; bits not yet written during RUN undefined
//   to consumer (out_valid=0).
//  Reset mid-RUN or mid-DONE: abort, return to reset values; no output.
//  Counter never exceeds NIB-1; no wrap.
// TESTING
//  1 add 5+3 (W=32): in_valid 1 cycle -> out_valid after 8 edges, result=8,
//    cout=0, overflow=0, zero=0.
//  2 add FFFFFFFF+00000001 -> result=0, cout=1, zero=1, overflow=0.
//  3 add 7FFFFFFF+1 -> result=80000000, overflow=1, cout=0.
//  4 sub 3-5 -> result=FFFFFFFE, cout=0, overflow=0; sub 5-5 -> 0, cout=1, zero=1.
//  5 backpressure: out_ready=0 for 10 cycles -> out_valid and result held,
//    in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
//  6 rst asserted at nibble 4 of a run -> out_valid=0, in_ready=1 immediately;
//    following op 1+1 returns 2 with correct latency.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit add/subtract unit. One 4-bit adder slice is reused
//   once per clock, least significant nibble first. The carry between nibbles
//   is kept in a register. Result, carry-out, signed overflow and zero are
//   assembled in registers and presented together when the operation is done.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      a, b, sub are valid this cycle
//   in_ready   out  1      unit can accept operands (IDLE only)
//   a, b       in   WIDTH  operands
//   sub        in   1      0: a+b, 1: a-b (computed as a + ~b + 1)
//   out_valid  out  1      result/flags valid; held until accepted
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  sum or difference
//   cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//   overflow   out  1      signed overflow
//   zero       out  1      result == 0
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE. Once
// out_valid is raised, it stays high with stable data until out_ready is
// seen. The FSM goes through IDLE between operations, so a new operand pair
// is never taken on the same edge that a result is consumed.

module adder_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q, ovf_q, zero_q;

  logic [3:0] a_nib, b_nib, slice_sum;
  logic       slice_cout;

  // Operand nibbles for the current step.
  always_comb begin
    a_nib = a_q[4*cnt +: 4];
    b_nib = b_q[4*cnt +: 4];
  end

  adder_4bits u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // The result after this step. The zero flag is taken from this value, so
  // it includes the last nibble that is written on the final edge.
  always_comb begin
    result_nxt = result_q;
    result_nxt[4*cnt +: 4] = slice_sum;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = RUN;
      RUN:     if (cnt == LAST)  state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is stored as a + ~b with the +1 carried in.
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          result_q <= result_nxt;
          carry    <= slice_cout;
          if (cnt == LAST) begin
            cout_q <= slice_cout;
            // b_q is already inverted for sub, so this one rule covers both.
            ovf_q  <= (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (slice_sum[3] ^ a_q[WIDTH-1]);
            zero_q <= (result_nxt == '0);
            // cnt holds at LAST. It never wraps.
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule
